sdram_arbit: RTL
================

# sdram_arbit

Command arbiter and refresh scheduler between the SDRAM init, write and read engines and the SDRAM pins. It grants the bus to one engine at a time with priority refresh > write > read. It generates the periodic auto-refresh request that the write and read engines monitor, and executes the auto-refresh itself. It muxes each engine's command, address, bank and data onto the device pins with zero added latency.

## Interface
Parameters:
- REF_PERIOD, 750: cycles between refresh requests (15 µs at 50 MHz).
- TRFC, 7: cycles spent in AREF, counted from the AREF command cycle; must be ≥ 2.

Ports:
- sclk, in, 1: system clock; all logic on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- init_end, in, 1: level; init engine finished.
- init_cmd, in, 4: init engine command.
- init_addr, in, 12: init engine address.
- ref_req, out, 1: refresh pending, to the write and read engines.
- wr_req, in, 1: write engine requests the bus.
- wr_en, out, 1: one-cycle grant pulse to the write engine.
- flag_wr_end, in, 1: one-cycle pulse; write engine released the bus.
- wr_cmd, in, 4: write engine command.
- wr_addr, in, 12: write engine address.
- wr_bank, in, 2: write engine bank.
- wr_data, in, 16: write engine data.
- rd_req, in, 1: read engine requests the bus.
- rd_en, out, 1: one-cycle grant pulse to the read engine.
- flag_rd_end, in, 1: one-cycle pulse; read engine released the bus.
- rd_cmd, in, 4: read engine command.
- rd_addr, in, 12: read engine address.
- rd_bank, in, 2: read engine bank.
- sdram_cke, out, 1: clock enable.
- sdram_cs_n, out, 1: chip select, active-low.
- sdram_ras_n, out, 1: row address strobe, active-low.
- sdram_cas_n, out, 1: column address strobe, active-low.
- sdram_we_n, out, 1: write enable, active-low.
- sdram_ba, out, 2: bank address.
- sdram_addr, out, 12: address bus.
- sdram_dq_out, out, 16: write data.
- sdram_dq_oe, out, 1: dq output enable.

## Operation
- Command encoding {cs_n,ras_n,cas_n,we_n}: NOP 0111, PRE 0010, AREF 0001, ACT 0011, WR 0100, RD 0101.
- State register is one-hot: IDLE, ARBIT, AREF, WRITE, READ.
- IDLE: pins carry init_cmd/init_addr, ba = 0. Go to ARBIT when init_end = 1.
- ARBIT: pins carry NOP, addr = 0, ba = 0.
  - If ref_req, go to AREF.
  - Else if wr_req, go to WRITE.
  - Else if rd_req, go to READ.
  - Else stay in ARBIT.
- WRITE: pins carry wr_cmd/wr_addr/wr_bank; sdram_dq_out = wr_data; sdram_dq_oe = 1. Go to ARBIT on flag_wr_end.
- READ: pins carry rd_cmd/rd_addr/rd_bank; dq_oe = 0. Go to ARBIT on flag_rd_end.
- AREF: internal ref_cnt counts 0..TRFC-1.
  - ref_cnt = 0: pins carry AREF with addr = 12'h400.
  - Other counts: pins carry NOP.
  - Go to ARBIT when ref_cnt = TRFC-1.
- Mux is combinational from state: no extra pipeline stage. sdram_dq_oe = (state == WRITE). sdram_dq_out = wr_data in every state.
- Refresh timer:
  - Held at 0 until init_end = 1, then counts 0..REF_PERIOD-1 and wraps.
  - At count REF_PERIOD-1, ref_req sets.
  - ref_req clears in the AREF command cycle (ref_cnt = 0). Set has priority if both occur together.
- Grants:
  - wr_en is registered and high for exactly the first cycle in WRITE, i.e. the cycle after the ARBIT→WRITE edge. rd_en behaves the same way for READ.
  - The write engine stays in its request state until it sees wr_en. wr_en is never high in any other WRITE cycle, so a write engine back in its request state after a refresh-forced release cannot be re-granted spuriously.
- flag_wr_end / flag_rd_end outside their own state are ignored.
- wr_req is ignored while ref_req = 1: refresh always wins the next arbitration.

## Timing
- Reset values:
  - state = IDLE; ref_req = 0; wr_en = 0; rd_en = 0; counters = 0.
  - sdram_cke = 1.
  - Pins follow init_cmd/init_addr; dq_oe = 0.
- ARBIT → grant state: 1 cycle. Grant pulse appears 1 cycle after the decision edge.
- A full refresh occupies exactly TRFC cycles in AREF, plus 1 cycle in ARBIT before and after.
- Refresh during a write:
  - ref_req stays high.
  - The write engine precharges and pulses flag_wr_end.
  - The arbiter returns to ARBIT next cycle, then enters AREF.
  - The write engine re-requests; it is granted after AREF ends.
- Timer overrun: if the timer wraps again while ref_req is still set, ref_req stays 1. Only one refresh is owed.
- Reset mid-operation: everything returns to reset values asynchronously. The timer does not run until init_end reasserts.

## Test plan
- Reset then init_end = 1 at cycle 10, no other requests, REF_PERIOD = 750, TRFC = 7 -> ref_req rises after 750 counted cycles; AREF (0001, addr 12'h400) appears once; 6 NOPs follow; ref_req low from the AREF cycle.
- wr_req and rd_req both high in ARBIT with ref_req = 0 -> WRITE entered; wr_en high exactly 1 cycle; rd_en stays 0; READ entered only after flag_wr_end.
- In WRITE, wr_cmd = 0100, wr_addr = 12'h005, wr_data = 16'hA5A5 -> pins show we_n = 0, cas_n = 0, ras_n = 1, addr = 12'h005, dq_out = 16'hA5A5, dq_oe = 1 in the same cycle.
- ref_req rises mid-write; writer pulses flag_wr_end 10 cycles later with wr_req still high -> ARBIT, AREF (7 cycles), ARBIT, then WRITE with a new 1-cycle wr_en.
- init_end = 0: init_cmd = 0010, init_addr = 12'h400 -> pins show PRE with addr 12'h400; wr_req = 1 is ignored and wr_en stays 0.
- Assert reset in cycle 3 of AREF -> ref_req = 0, state = IDLE, wr_en = 0, rd_en = 0 immediately; no AREF issued until re-init plus REF_PERIOD.

Source files
------------

// File: rtl/sdram_arbit.sv
// Bus arbiter between the SDRAM init, write and read engines, plus the periodic
// auto-refresh scheduler. Engine commands reach the pins combinationally from the state.
module sdram_arbit #(
  parameter int REF_PERIOD = 750,
  parameter int TRFC       = 7
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  output logic        ref_req,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic [15:0] wr_data,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  localparam int TW = $clog2(REF_PERIOD);
  localparam int CW = $clog2(TRFC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REF_PERIOD - 1);
  localparam logic [CW-1:0] AREF_LAST  = CW'(TRFC - 1);
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ARBIT = 5'b00010,
    AREF  = 5'b00100,
    WRITE = 5'b01000,
    READ  = 5'b10000
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TW-1:0]   ref_timer;
  logic [CW-1:0]   ref_cnt;
  logic [3:0]      cmd;

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Refresh always wins arbitration, so a pending refresh also overrides wr_req.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (init_end) state_next = ARBIT;
      ARBIT: begin
        if (ref_req)      state_next = AREF;
        else if (wr_req)  state_next = WRITE;
        else if (rd_req)  state_next = READ;
      end
      AREF:    if (ref_cnt == AREF_LAST) state_next = ARBIT;
      WRITE:   if (flag_wr_end) state_next = ARBIT;
      READ:    if (flag_rd_end) state_next = ARBIT;
      default: state_next = IDLE;
    endcase
  end

  // Grants fire only on the ARBIT exit edge, never while an engine already owns the bus.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
    end else begin
      wr_en <= (state == ARBIT) && (state_next == WRITE);
      rd_en <= (state == ARBIT) && (state_next == READ);
    end
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset)                                    ref_cnt <= '0;
    else if (state == AREF && ref_cnt != AREF_LAST) ref_cnt <= ref_cnt + 1'b1;
    else                                           ref_cnt <= '0;
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset)                      ref_timer <= '0;
    else if (!init_end)              ref_timer <= '0;
    else if (ref_timer == TIMER_LAST) ref_timer <= '0;
    else                             ref_timer <= ref_timer + 1'b1;
  end

  // A new request beats the clear, and overruns just keep the single owed refresh.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset)                                  ref_req <= 1'b0;
    else if (init_end && ref_timer == TIMER_LAST) ref_req <= 1'b1;
    else if (state == AREF && ref_cnt == '0)      ref_req <= 1'b0;
  end

  always_comb begin
    cmd        = CMD_NOP;
    sdram_addr = 12'h000;
    sdram_ba   = 2'b00;
    case (state)
      IDLE: begin
        cmd        = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        if (ref_cnt == '0) begin
          cmd        = CMD_AREF;
          sdram_addr = 12'h400;
        end
      end
      WRITE: begin
        cmd        = wr_cmd;
        sdram_addr = wr_addr;
        sdram_ba   = wr_bank;
      end
      READ: begin
        cmd        = rd_cmd;
        sdram_addr = rd_addr;
        sdram_ba   = rd_bank;
      end
      default: begin
        cmd        = CMD_NOP;
        sdram_addr = 12'h000;
        sdram_ba   = 2'b00;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke    = 1'b1;
  assign sdram_dq_out = wr_data;
  assign sdram_dq_oe  = (state == WRITE);

endmodule
